// File: rtl/daq_fifo_writer.sv
// daq_fifo_writer: frames a non-stallable 16-bit link word stream into
// 18-bit FIFO words {last, first, data}. Events are closed with a trailer
// on FIFO almost-full, on excessive length or on a link stall, so the
// reader always sees properly terminated events.
module daq_fifo_writer #(
  parameter logic [11:0] MAXWDS = 12'd448,
  parameter logic [7:0]  TMO    = 8'd40
) (
  input  logic        CLKCMS,
  input  logic        RST,
  input  logic        DIN_VALID,
  input  logic [15:0] DIN,
  input  logic        DIN_LAST,
  input  logic        FAF_B,
  output logic        WRENFIFO_B,
  output logic [17:0] FDATA,
  output logic        DAV,
  output logic [7:0]  EVTCNT,
  output logic [7:0]  DROPCNT,
  output logic [2:0]  ERRFLG,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [3:0] TRL_FULL = 4'hE;
  localparam logic [3:0] TRL_MAX  = 4'hC;
  localparam logic [3:0] TRL_TMO  = 4'hD;

  state_t      r_state;
  logic [11:0] r_wcnt;
  logic [7:0]  r_idle;
  logic        r_wren_b;
  logic [17:0] r_fdata;
  logic        r_dav;
  logic [7:0]  r_evtcnt;
  logic [7:0]  r_dropcnt;
  logic [2:0]  r_errflg;
  logic        r_busy;

  logic [7:0]  w_idle_nxt;
  logic        w_tmo_hit;
  logic        w_max_hit;

  // Stall counter look-ahead and event length limit
  assign w_idle_nxt = r_idle + 8'd1;
  assign w_tmo_hit  = (w_idle_nxt == TMO);
  assign w_max_hit  = (r_wcnt == (MAXWDS - 12'd1));

  // Framing FSM with registered FIFO write port, counters and flags
  always_ff @(posedge CLKCMS) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_wcnt    <= 12'd0;
      r_idle    <= 8'd0;
      r_wren_b  <= 1'b1;
      r_fdata   <= 18'd0;
      r_dav     <= 1'b0;
      r_evtcnt  <= 8'd0;
      r_dropcnt <= 8'd0;
      r_errflg  <= 3'd0;
      r_busy    <= 1'b0;
    end else begin
      r_wren_b <= 1'b1;
      r_dav    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (DIN_VALID) begin
            if (!FAF_B) begin
              // No room for a whole event: discard it without any write
              if (r_dropcnt != 8'hFF) r_dropcnt <= r_dropcnt + 8'd1;
              if (!DIN_LAST) begin
                r_state <= S_DROP;
                r_busy  <= 1'b1;
              end
            end else begin
              r_wren_b <= 1'b0;
              r_fdata  <= {DIN_LAST, 1'b1, DIN};
              r_wcnt   <= 12'd1;
              r_idle   <= 8'd0;
              if (DIN_LAST) begin
                r_dav    <= 1'b1;
                r_evtcnt <= r_evtcnt + 8'd1;
              end else begin
                r_state <= S_DATA;
                r_busy  <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (DIN_VALID) begin
            r_idle <= 8'd0;
            if (DIN_LAST) begin
              r_wren_b <= 1'b0;
              r_fdata  <= {2'b10, DIN};
              r_dav    <= 1'b1;
              r_evtcnt <= r_evtcnt + 8'd1;
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
            end else if (!FAF_B) begin
              r_wren_b    <= 1'b0;
              r_fdata     <= {2'b10, TRL_FULL, r_wcnt};
              r_dav       <= 1'b1;
              r_evtcnt    <= r_evtcnt + 8'd1;
              r_errflg[2] <= 1'b1;
              r_state     <= S_DROP;
            end else if (w_max_hit) begin
              r_wren_b    <= 1'b0;
              r_fdata     <= {2'b10, TRL_MAX, r_wcnt};
              r_dav       <= 1'b1;
              r_evtcnt    <= r_evtcnt + 8'd1;
              r_errflg[0] <= 1'b1;
              r_state     <= S_DROP;
            end else begin
              r_wren_b <= 1'b0;
              r_fdata  <= {2'b00, DIN};
              r_wcnt   <= r_wcnt + 12'd1;
            end
          end else begin
            r_idle <= w_idle_nxt;
            if (w_tmo_hit) begin
              r_wren_b    <= 1'b0;
              r_fdata     <= {2'b10, TRL_TMO, r_wcnt};
              r_dav       <= 1'b1;
              r_evtcnt    <= r_evtcnt + 8'd1;
              r_errflg[1] <= 1'b1;
              r_idle      <= 8'd0;
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (DIN_VALID && DIN_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign WRENFIFO_B = r_wren_b;
  assign FDATA      = r_fdata;
  assign DAV        = r_dav;
  assign EVTCNT     = r_evtcnt;
  assign DROPCNT    = r_dropcnt;
  assign ERRFLG     = r_errflg;
  assign BUSY       = r_busy;

endmodule

// File: tb/tb_daq_fifo_writer.sv
// tb_daq_fifo_writer: randomized and directed stimulus against an
// event-level reference model; expected FIFO words go into a scoreboard
// queue that an independent monitor drains whenever the DUT writes.
module tb_daq_fifo_writer;

  localparam logic [11:0] MAXW = 12'd8;
  localparam logic [7:0]  TMOP = 8'd40;
  localparam int          MAXW_I = 8;
  localparam int          TMO_I  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [15:0] din = 16'd0;
  logic        din_last = 1'b0;
  logic        faf_b = 1'b1;
  logic        wren_b;
  logic [17:0] fdata;
  logic        dav;
  logic [7:0]  evtcnt;
  logic [7:0]  dropcnt;
  logic [2:0]  errflg;
  logic        busy;

  always #5 clk = ~clk;

  daq_fifo_writer #(.MAXWDS(MAXW), .TMO(TMOP)) dut (
    .CLKCMS    (clk),
    .RST       (rst),
    .DIN_VALID (din_valid),
    .DIN       (din),
    .DIN_LAST  (din_last),
    .FAF_B     (faf_b),
    .WRENFIFO_B(wren_b),
    .FDATA     (fdata),
    .DAV       (dav),
    .EVTCNT    (evtcnt),
    .DROPCNT   (dropcnt),
    .ERRFLG    (errflg),
    .BUSY      (busy)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model: event-level bookkeeping
  logic [17:0] exp_q[$];
  bit          m_in_evt  = 1'b0;
  bit          m_dropping = 1'b0;
  int          m_words   = 0;
  int          m_gap     = 0;
  logic [7:0]  m_evt     = 8'd0;
  logic [7:0]  m_dropc   = 8'd0;
  logic [2:0]  m_err     = 3'd0;
  bit          m_rst_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic close_with(input logic [3:0] code, input int bitn, input bit to_drop);
    logic [11:0] n;
    n = 12'(m_words);
    exp_q.push_back({2'b10, code, n});
    m_evt++;
    m_err[bitn] = 1'b1;
    m_in_evt = 1'b0;
    m_dropping = to_drop;
  endtask

  task automatic model(input bit v, input bit l, input logic [15:0] d, input bit f, input bit r);
    if (r) begin
      m_in_evt = 0; m_dropping = 0; m_words = 0; m_gap = 0;
      m_evt = 0; m_dropc = 0; m_err = 0; m_rst_chk = 1;
    end else if (m_in_evt) begin
      if (v) begin
        m_gap = 0;
        if (l) begin
          exp_q.push_back({2'b10, d});
          m_evt++;
          m_in_evt = 0;
        end else if (!f) close_with(4'hE, 2, 1'b1);
        else if (m_words == MAXW_I - 1) close_with(4'hC, 0, 1'b1);
        else begin
          exp_q.push_back({2'b00, d});
          m_words++;
        end
      end else begin
        m_gap++;
        if (m_gap == TMO_I) close_with(4'hD, 1, 1'b0);
      end
    end else if (m_dropping) begin
      if (v && l) m_dropping = 0;
    end else if (v) begin
      if (!f) begin
        if (m_dropc != 8'hFF) m_dropc++;
        m_dropping = !l;
      end else begin
        exp_q.push_back({l, 1'b1, d});
        m_words = 1;
        m_gap = 0;
        if (l) m_evt++;
        else m_in_evt = 1;
      end
    end
  endtask

  // Apply one cycle of stimulus away from the sampling edge
  task automatic drive(input bit v, input bit l, input logic [15:0] d, input bit f, input bit r);
    @(negedge clk);
    rst = r; din_valid = v; din_last = l; din = d; faf_b = f;
    model(v, l, d, f, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  // Event of n words; FAF_B goes low from word index faf_at onwards (-1: never)
  task automatic event_w(input int n, input logic [15:0] start, input logic [15:0] step, input int faf_at);
    logic [15:0] d;
    d = start;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i == n - 1), d, !(faf_at >= 0 && i >= faf_at), 1'b0);
      d = d + step;
    end
  endtask

  // Monitor: pop and compare on every DUT write, track status outputs
  initial begin
    logic [17:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (wren_b === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_write actual=%h required=none t=%0t", fdata, $time);
          end else begin
            e = exp_q.pop_front();
            chk("fdata", 32'(fdata), 32'(e));
            chk("dav_write", 32'(dav), 32'(e[17]));
          end
        end else begin
          chk("dav_nowrite", 32'(dav), 32'd0);
        end
        chk("evtcnt", 32'(evtcnt), 32'(m_evt));
        chk("dropcnt", 32'(dropcnt), 32'(m_dropc));
        chk("errflg", 32'(errflg), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_in_evt || m_dropping));
        if (m_rst_chk) begin
          chk("rst_wren", 32'(wren_b), 32'd1);
          chk("rst_fdata", 32'(fdata), 32'd0);
          m_rst_chk = 1'b0;
        end
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    mon_on = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    idle(2);

    // 5-word event, then single-word event
    event_w(5, 16'h1111, 16'h1111, -1);
    idle(3);
    event_w(1, 16'hABCD, 16'h0, -1);
    idle(2);

    // Almost-full after the 3rd word of a 10-word event, then a normal event
    event_w(10, 16'h0100, 16'h1, 3);
    event_w(3, 16'h0200, 16'h1, -1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Dropped at start, then saturation of the drop counter
    event_w(3, 16'h0300, 16'h1, 0);
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Maximum length: 20-word event truncated, 8-word event intact
    event_w(20, 16'h0400, 16'h1, -1);
    event_w(8, 16'h0500, 16'h1, -1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Timeout after a 40-cycle gap; late words form a new event
    event_w(4, 16'h0600, 16'h1, -1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0600 + 16'(i), 1'b1, 1'b0);
    idle(TMO_I);
    event_w(2, 16'h0700, 16'h1, -1);
    // 39-cycle gap is tolerated
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0800 + 16'(i), 1'b1, 1'b0);
    idle(TMO_I - 1);
    event_w(2, 16'h0900, 16'h1, -1);

    // Reset in the middle of an event
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0A00 + 16'(i), 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0A03, 1'b1, 1'b1);
    event_w(3, 16'h0A04, 16'h1, -1);

    // Randomized traffic
    for (int ev = 0; ev < 150; ev++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        int g;
        g = int'($urandom_range(0, 99));
        if (g < 20) idle(int'($urandom_range(1, 3)));
        else if (g < 23) idle(int'($urandom_range(36, 44)));
        drive(1'b1, (i == n - 1), 16'($urandom), ($urandom_range(0, 19) != 0),
              ($urandom_range(0, 199) == 0));
      end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
    end
    idle(TMO_I + 2);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
